// File: rtl/wpn_pkg.sv
// Shared types, default tuning values and 12-bit saturating arithmetic
// for the weapon controllers.
package wpn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWING_FWD  = 2'd1,
    SWING_BACK = 2'd2,
    COOLDOWN   = 2'd3
  } melee_state_t;

  localparam int SWING_STEPS_DEF     = 10;
  localparam int STEP_PX_DEF         = 2;
  localparam int OFFSET_X_DEF        = 20;
  localparam int OFFSET_Y_DEF        = 4;
  localparam int COOLDOWN_FRAMES_DEF = 8;

  // Both helpers widen to 13 bits so the carry/borrow shows up as bit 12.
  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[12] ? 12'hFFF : sum[11:0];
  endfunction

  function automatic logic [11:0] sat_sub12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[12] ? 12'h000 : diff[11:0];
  endfunction

endpackage

// File: rtl/wpn_click_sync.sv
// Two-flop synchronizer for an asynchronous button followed by a registered
// rising-edge pulse; shared by the melee and ranged weapon controllers.
module wpn_click_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic click_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic click_q;

  // Button edge becomes a single-cycle pulse three clocks after it happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      click_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      click_q <= sync2_q & ~prev_q;
    end
  end

  assign click_o = click_q;

endmodule

// File: rtl/wpn_melee_ctrl.sv
// Melee swing controller: turns clicks into a frame-paced forward/back swing
// and drives the weapon anchor, facing and visibility of the draw stage.
module wpn_melee_ctrl
  import wpn_pkg::*;
#(
  parameter int SWING_STEPS     = SWING_STEPS_DEF,
  parameter int STEP_PX         = STEP_PX_DEF,
  parameter int OFFSET_X        = OFFSET_X_DEF,
  parameter int OFFSET_Y        = OFFSET_Y_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x,
  input  logic [11:0] char_x,
  input  logic [11:0] char_y,
  output logic [11:0] pos_x_wpn_offset,
  output logic [11:0] pos_y_wpn_offset,
  output logic        mouse_clicked,
  output logic        flip_h,
  output logic        hit_strobe,
  output logic        busy
);

  localparam logic [7:0]  SWING_LAST = 8'(SWING_STEPS - 1);
  localparam logic [7:0]  CD_LAST    = (COOLDOWN_FRAMES > 0) ? 8'(COOLDOWN_FRAMES - 1) : 8'd0;
  localparam logic [11:0] STEP12     = 12'(STEP_PX);
  localparam logic [11:0] OFFX12     = 12'(OFFSET_X);
  localparam logic [11:0] OFFY12     = 12'(OFFSET_Y);

  logic         click;
  logic         flip_live;
  logic         eff_flip;

  melee_state_t state_q;
  logic [7:0]   cnt_q;
  logic [11:0]  anim_q;
  logic         pending_q;
  logic         flip_q;
  logic         hit_q;

  logic [11:0]  pos_x_q;
  logic [11:0]  pos_y_q;
  logic         clicked_q;
  logic         flip_h_q;
  logic         hit_strobe_q;
  logic         busy_q;

  wpn_click_sync u_click_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (mouse_left),
    .click_o (click)
  );

  assign flip_live = (mouse_x < char_x);
  assign eff_flip  = (state_q == IDLE) ? flip_live : flip_q;

  // Facing and the request buffer run every clock; the swing itself only
  // moves on frame ticks so its speed is independent of the pixel clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      anim_q    <= 12'd0;
      pending_q <= 1'b0;
      flip_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      hit_q <= 1'b0;

      if (state_q == IDLE) begin
        flip_q <= flip_live;
      end

      if ((state_q == IDLE) && frame_tick && (pending_q || click)) begin
        pending_q <= 1'b0;
      end else if (click && (state_q != SWING_FWD)) begin
        pending_q <= 1'b1;
      end

      if (frame_tick) begin
        case (state_q)
          IDLE: begin
            if (pending_q || click) begin
              state_q <= SWING_FWD;
              cnt_q   <= 8'd0;
              anim_q  <= 12'd0;
            end
          end
          SWING_FWD: begin
            anim_q <= anim_q + STEP12;
            if (cnt_q == SWING_LAST) begin
              state_q <= SWING_BACK;
              cnt_q   <= 8'd0;
              hit_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          SWING_BACK: begin
            if (cnt_q == SWING_LAST) begin
              anim_q  <= 12'd0;
              cnt_q   <= 8'd0;
              state_q <= (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
            end else begin
              anim_q <= (anim_q > STEP12) ? (anim_q - STEP12) : 12'd0;
              cnt_q  <= cnt_q + 8'd1;
            end
          end
          COOLDOWN: begin
            if (cnt_q == CD_LAST) begin
              state_q <= IDLE;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Positions follow the character in every state; visibility is gated
  // separately by mouse_clicked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_x_q      <= 12'd0;
      pos_y_q      <= 12'd0;
      clicked_q    <= 1'b0;
      flip_h_q     <= 1'b0;
      hit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pos_x_q      <= eff_flip ? sat_sub12(sat_sub12(char_x, OFFX12), anim_q)
                               : sat_add12(sat_add12(char_x, OFFX12), anim_q);
      pos_y_q      <= sat_add12(char_y, OFFY12);
      clicked_q    <= (state_q == SWING_FWD) || (state_q == SWING_BACK);
      flip_h_q     <= eff_flip;
      hit_strobe_q <= hit_q;
      busy_q       <= (state_q != IDLE);
    end
  end

  assign pos_x_wpn_offset = pos_x_q;
  assign pos_y_wpn_offset = pos_y_q;
  assign mouse_clicked    = clicked_q;
  assign flip_h           = flip_h_q;
  assign hit_strobe       = hit_strobe_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_wpn_melee_ctrl.sv
// Scoreboard bench for wpn_melee_ctrl: a tick-level model pushes expected
// outputs on every stimulus step, and each scenario pops and compares them.
module tb_wpn_melee_ctrl;

  typedef struct packed {
    logic        clicked;
    logic        busy;
    logic        flip;
    logic        hit;
    logic [11:0] px;
    logic [11:0] py;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_x = 12'd0;
  logic [11:0] char_x = 12'd0;
  logic [11:0] char_y = 12'd0;
  logic [11:0] pos_x_wpn_offset;
  logic [11:0] pos_y_wpn_offset;
  logic        mouse_clicked;
  logic        flip_h;
  logic        hit_strobe;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int hitCount = 0;

  // Reference model state, advanced once per frame tick.
  int   mState = 0;
  int   mCnt = 0;
  int   mAnim = 0;
  logic mPend = 1'b0;
  logic mFlip = 1'b0;
  logic mHit = 1'b0;

  obs_t sbq[$];

  wpn_melee_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .frame_tick       (frame_tick),
    .mouse_left       (mouse_left),
    .mouse_x          (mouse_x),
    .char_x           (char_x),
    .char_y           (char_y),
    .pos_x_wpn_offset (pos_x_wpn_offset),
    .pos_y_wpn_offset (pos_y_wpn_offset),
    .mouse_clicked    (mouse_clicked),
    .flip_h           (flip_h),
    .hit_strobe       (hit_strobe),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hit_strobe === 1'b1) hitCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic obs_t sample();
    obs_t o;
    o.clicked = mouse_clicked;
    o.busy    = busy;
    o.flip    = flip_h;
    o.hit     = hit_strobe;
    o.px      = pos_x_wpn_offset;
    o.py      = pos_y_wpn_offset;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("clk=%b busy=%b flip=%b hit=%b x=%0d y=%0d",
                     o.clicked, o.busy, o.flip, o.hit, o.px, o.py);
  endfunction

  function automatic obs_t expectObs();
    obs_t o;
    logic f;
    int   x;
    int   y;
    f = (mState == 0) ? (mouse_x < char_x) : mFlip;
    x = f ? (int'(char_x) - 20 - mAnim) : (int'(char_x) + 20 + mAnim);
    if (x < 0) x = 0;
    if (x > 4095) x = 4095;
    y = int'(char_y) + 4;
    if (y > 4095) y = 4095;
    o.clicked = (mState == 1) || (mState == 2);
    o.busy    = (mState != 0);
    o.flip    = f;
    o.hit     = mHit;
    o.px      = 12'(x);
    o.py      = 12'(y);
    return o;
  endfunction

  function automatic void modelTick();
    mHit = 1'b0;
    case (mState)
      0: if (mPend) begin
           mState = 1; mCnt = 0; mAnim = 0; mPend = 1'b0;
           mFlip = (mouse_x < char_x);
         end
      1: begin
           mAnim += 2;
           if (mCnt == 9) begin mState = 2; mCnt = 0; mHit = 1'b1; end
           else mCnt++;
         end
      2: if (mCnt == 9) begin mState = 3; mCnt = 0; mAnim = 0; end
         else begin mAnim -= 2; mCnt++; end
      default: if (mCnt == 7) begin mState = 0; mCnt = 0; end
               else mCnt++;
    endcase
  endfunction

  function automatic void modelClick();
    if (mState != 1) mPend = 1'b1;
  endfunction

  function automatic void modelReset();
    mState = 0; mCnt = 0; mAnim = 0; mPend = 1'b0; mFlip = 1'b0; mHit = 1'b0;
  endfunction

  // One frame tick; leaves the bench on the negedge where outputs reflect it.
  task automatic applyTick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    modelTick();
    sbq.push_back(expectObs());
    @(negedge clk);
  endtask

  task automatic applyClick();
    @(negedge clk) mouse_left = 1'b1;
    repeat (5) @(negedge clk);
    modelClick();
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t exp;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mouse_left = ~mouse_left;
      frame_tick = ~frame_tick;
      mouse_x    = 12'($urandom_range(0, 4095));
      char_x     = 12'($urandom_range(0, 4095));
      char_y     = 12'($urandom_range(0, 4095));
      @(negedge clk);
      got = sample();
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold: got %s, expected all zero", fmt(got));
      end
    end
    @(negedge clk);
    mouse_left = 1'b0; frame_tick = 1'b0;
    mouse_x = 12'd300; char_x = 12'd200; char_y = 12'd400;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    modelReset();
    sbq.push_back(expectObs());
    @(negedge clk);
    exp = sbq.pop_front();
    got = sample();
    vectors++;
    if (got !== exp || got.px !== 12'd220 || got.py !== 12'd404) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got %s, expected %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_basic_swing();
    obs_t got;
    obs_t exp;
    int   h0;
    h0 = hitCount;
    applyClick();
    for (int t = 0; t < 31; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL swing tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
    end
    vectors++;
    if (hitCount - h0 != 1) begin
      miscompares++;
      $display("[TB] FAIL swing_hits: got %0d, expected 1", hitCount - h0);
    end
  endtask

  task automatic test_drop_and_cooldown_click();
    obs_t got;
    obs_t exp;
    int   h0;
    h0 = hitCount;
    applyClick();
    for (int t = 1; t <= 60; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL requeue tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
      if (t == 4 || t == 24) applyClick();
    end
    vectors++;
    if (hitCount - h0 != 2) begin
      miscompares++;
      $display("[TB] FAIL requeue_hits: got %0d, expected 2", hitCount - h0);
    end
  endtask

  task automatic test_facing_and_saturation();
    obs_t got;
    obs_t exp;
    char_x = 12'd10; mouse_x = 12'd5; char_y = 12'd100;
    applyClick();
    for (int t = 1; t <= 32; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL facing tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
      if (t == 6) mouse_x = 12'd500;
    end
    char_x = 12'd4080; mouse_x = 12'd4095; char_y = 12'd4094;
    applyClick();
    for (int t = 1; t <= 6; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL sat_high tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
    end
    for (int t = 7; t <= 30; t++) begin
      applyTick();
      void'(sbq.pop_front());
    end
    mouse_x = 12'd300; char_x = 12'd200; char_y = 12'd400;
  endtask

  task automatic test_held_button();
    obs_t got;
    obs_t exp;
    int   h0;
    h0 = hitCount;
    @(negedge clk) mouse_left = 1'b1;
    repeat (5) @(negedge clk);
    modelClick();
    for (int t = 1; t <= 100; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL held tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
    end
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (hitCount - h0 != 1) begin
      miscompares++;
      $display("[TB] FAIL held_hits: got %0d, expected 1", hitCount - h0);
    end
  endtask

  task automatic test_click_before_tick();
    obs_t got;
    obs_t exp;
    @(negedge clk) mouse_left = 1'b1;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    modelTick();
    sbq.push_back(expectObs());
    @(negedge clk);
    exp = sbq.pop_front();
    got = sample();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL early_click_tick: got %s, expected %s", fmt(got), fmt(exp));
    end
    repeat (3) @(negedge clk);
    modelClick();
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
    for (int t = 1; t <= 30; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL early_click tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_reset_midswing();
    obs_t got;
    obs_t exp;
    int   h0;
    applyClick();
    for (int t = 1; t <= 6; t++) begin
      applyTick();
      void'(sbq.pop_front());
    end
    h0 = hitCount;
    #2 rst = 1'b0;
    #1 got = sample();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %s, expected all zero", fmt(got));
    end
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      applyTick();
      exp = sbq.pop_front();
      got = sample();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("[TB] FAIL post_reset tick%0d: got %s, expected %s", t, fmt(got), fmt(exp));
      end
    end
    vectors++;
    if (hitCount != h0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_hits: got %0d, expected %0d", hitCount, h0);
    end
  endtask

  initial begin
    $display("[TB] starting wpn_melee_ctrl scenarios");
    test_reset();
    test_basic_swing();
    test_drop_and_cooldown_click();
    test_facing_and_saturation();
    test_held_button();
    test_click_before_tick();
    test_reset_midswing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
